// File: rtl/park_transform_seq_pkg.sv
// -----------------------------------------------------------------------------
// park_pkg
// Shared definitions for the sequential Park / inverse Park transform:
//   - transform mode encodings (MODE_INV, MODE_FWD)
//   - controller state encoding (IDLE, MUL, FIN, DONE)
//   - round_shift : round-half-up arithmetic right shift
//   - sat_signed  : clamp to a signed range of a given width
// Both helpers work on a MAX_W-wide signed carrier. The shift amount and the
// target width are arguments, so one definition serves any DATA_W/FRAC_W whose
// accumulator fits in MAX_W bits.
// -----------------------------------------------------------------------------
package park_pkg;

    localparam logic MODE_INV = 1'b0;
    localparam logic MODE_FWD = 1'b1;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // (a + 2^(sh-1)) >>> sh ; ties round toward +infinity.
    function automatic logic signed [MAX_W-1:0] round_shift(
        input logic signed [MAX_W-1:0] a,
        input int                      sh
    );
        logic signed [MAX_W-1:0] half;
        half = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        return (a + half) >>> sh;
    endfunction

    // Clamp a to [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [MAX_W-1:0] sat_signed(
        input logic signed [MAX_W-1:0] a,
        input int                      w
    );
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (a > hi) begin
            return hi;
        end else if (a < lo) begin
            return lo;
        end
        return a;
    endfunction

endpackage

// File: rtl/park_transform_seq_if.sv
// -----------------------------------------------------------------------------
// park_transform_seq_if
// Request/result bundle of the sequential Park transform.
//   iEn    start request (rising edge while idle starts a transaction)
//   iMode  0 = inverse Park, 1 = forward Park
//   iSin   sin(theta), Q1.FRAC_W        iCos  cos(theta), Q1.FRAC_W
//   iX     Vd / Valpha                  iY    Vq / Vbeta
//   oBusy  transaction in flight        oDone one-cycle completion pulse
//   oOut0  Valpha / Vd                  oOut1 Vbeta / Vq
//   oSat   an output clipped in the last transaction
// master drives the request side, slave (the transform) drives the results.
// -----------------------------------------------------------------------------
interface park_transform_seq_if #(
    parameter int DATA_W = 16
);
    logic                     iEn;
    logic                     iMode;
    logic signed [DATA_W-1:0] iSin;
    logic signed [DATA_W-1:0] iCos;
    logic signed [DATA_W-1:0] iX;
    logic signed [DATA_W-1:0] iY;
    logic                     oBusy;
    logic                     oDone;
    logic signed [DATA_W-1:0] oOut0;
    logic signed [DATA_W-1:0] oOut1;
    logic                     oSat;

    modport master (
        output iEn, iMode, iSin, iCos, iX, iY,
        input  oBusy, oDone, oOut0, oOut1, oSat
    );

    modport slave (
        input  iEn, iMode, iSin, iCos, iX, iY,
        output oBusy, oDone, oOut0, oOut1, oSat
    );
endinterface

// File: rtl/park_transform_seq_mac.sv
// -----------------------------------------------------------------------------
// park_mac
// Registered signed multiply-accumulate: acc <= acc +/- a*b when enabled.
//   clk_i, rst_i  clock, synchronous active-high reset (clears acc)
//   a_i, b_i      signed operands, DATA_W bits
//   sub_i         1 = subtract the product, 0 = add it
//   clr_i         clear the accumulator (takes priority over en_i)
//   en_i          accumulate this cycle
//   acc_o         accumulator, ACC_W bits, full precision
// -----------------------------------------------------------------------------
module park_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2*DATA_W+2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic                     sub_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    output logic signed [ACC_W-1:0]  acc_o
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;

    // Full 2*DATA_W product: (-2^(W-1))^2 = 2^(2W-2) still fits.
    assign prod     = a_i * b_i;
    assign prod_ext = prod;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/park_transform_seq.sv
// -----------------------------------------------------------------------------
// park_transform_seq
// Inverse Park (dq -> alpha/beta) or forward Park (alpha/beta -> dq), chosen per
// transaction, computed with one multiplier time-shared over four cycles.
//   iClk  clock (rising edge)      iRst  synchronous active-high reset
//   bus   park_transform_seq_if.slave (request inputs, results, status)
// Timeline from the start edge T: products at T+1..T+4, round/saturate at T+5,
// outputs and oDone at T+6, oBusy low from T+7.
// -----------------------------------------------------------------------------
module park_transform_seq
    import park_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int FRAC_W = DATA_W-1,
    localparam int ACC_W  = 2*DATA_W+2
) (
    input  logic                        iClk,
    input  logic                        iRst,
    park_transform_seq_if.slave         bus
);
    state_t                   state_q, state_d;
    logic [1:0]               k_q, k_d;
    logic                     en_q;
    logic                     start;

    logic                     mode_q;
    logic signed [DATA_W-1:0] sin_q, cos_q, x_q, y_q;

    logic signed [DATA_W-1:0] op_a, op_b;
    logic                     clr;
    logic                     en0, en1;
    logic                     sub0, sub1;
    logic signed [ACC_W-1:0]  acc0, acc1;

    logic signed [MAX_W-1:0]  a0_ext, a1_ext;
    logic signed [MAX_W-1:0]  rs0, rs1, sat0, sat1;
    logic                     clip0, clip1;

    logic signed [DATA_W-1:0] res0_q, res1_q;
    logic                     rsat_q;
    logic signed [DATA_W-1:0] out0_q, out1_q;
    logic                     sat_q, done_q, busy_q;

    assign start = bus.iEn & ~en_q & (state_q == IDLE);

    // Controller: sequencing plus the shared operand select feeding both MACs.
    // P0 = X*Cos and P1 = Y*Sin go to A0, P2 = X*Sin and P3 = Y*Cos go to A1.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        clr     = 1'b0;
        en0     = 1'b0;
        en1     = 1'b0;
        sub0    = 1'b0;
        sub1    = 1'b0;
        op_a    = x_q;
        op_b    = cos_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MUL;
                    k_d     = 2'd0;
                    clr     = 1'b1;
                end
            end
            MUL: begin
                k_d = k_q + 2'd1;
                unique case (k_q)
                    2'd0: begin
                        op_a = x_q;
                        op_b = cos_q;
                        en0  = 1'b1;
                    end
                    2'd1: begin
                        op_a = y_q;
                        op_b = sin_q;
                        en0  = 1'b1;
                        sub0 = (mode_q == MODE_INV);
                    end
                    2'd2: begin
                        op_a = x_q;
                        op_b = sin_q;
                        en1  = 1'b1;
                        sub1 = (mode_q == MODE_FWD);
                    end
                    default: begin
                        op_a    = y_q;
                        op_b    = cos_q;
                        en1     = 1'b1;
                        state_d = FIN;
                    end
                endcase
            end
            FIN:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    park_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_a0 (
        .clk_i (iClk),
        .rst_i (iRst),
        .a_i   (op_a),
        .b_i   (op_b),
        .sub_i (sub0),
        .clr_i (clr),
        .en_i  (en0),
        .acc_o (acc0)
    );

    park_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_a1 (
        .clk_i (iClk),
        .rst_i (iRst),
        .a_i   (op_a),
        .b_i   (op_b),
        .sub_i (sub1),
        .clr_i (clr),
        .en_i  (en1),
        .acc_o (acc1)
    );

    // Round-half-up back to Q-format, then clamp; a clip is any change by the clamp.
    always_comb begin
        a0_ext = acc0;
        a1_ext = acc1;
        rs0    = round_shift(a0_ext, FRAC_W);
        rs1    = round_shift(a1_ext, FRAC_W);
        sat0   = sat_signed(rs0, DATA_W);
        sat1   = sat_signed(rs1, DATA_W);
        clip0  = (sat0 != rs0);
        clip1  = (sat1 != rs1);
    end

    // Control and visible outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            en_q    <= bus.iEn;
            done_q  <= (state_q == DONE);
            if (start) begin
                busy_q <= 1'b1;
            end else if (done_q) begin
                busy_q <= 1'b0;
            end
            // Results become visible together with oDone and hold until the next one.
            if (state_q == DONE) begin
                out0_q <= res0_q;
                out1_q <= res1_q;
                sat_q  <= rsat_q;
            end
        end
    end

    // Operand latch and rounded/saturated result staging.
    always_ff @(posedge iClk) begin
        if (start) begin
            mode_q <= bus.iMode;
            sin_q  <= bus.iSin;
            cos_q  <= bus.iCos;
            x_q    <= bus.iX;
            y_q    <= bus.iY;
        end
        if (state_q == FIN) begin
            res0_q <= sat0[DATA_W-1:0];
            res1_q <= sat1[DATA_W-1:0];
            rsat_q <= clip0 | clip1;
        end
    end

    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;
    assign bus.oOut0 = out0_q;
    assign bus.oOut1 = out1_q;
    assign bus.oSat  = sat_q;
endmodule

// File: tb/tb_park_transform_seq.sv
// -----------------------------------------------------------------------------
// tb_park_transform_seq
// Directed vectors with hand-computed results for park_transform_seq, plus a
// randomised sweep against a real-valued model of the transform.
// -----------------------------------------------------------------------------
module tb_park_transform_seq;
    logic clk;
    logic rst;

    park_transform_seq_if #(.DATA_W(16)) bus();

    park_transform_seq #(.DATA_W(16)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_txn(input logic m, input int s, input int c, input int x, input int y);
        @(negedge clk);
        bus.iMode = m;
        bus.iSin  = 16'(s);
        bus.iCos  = 16'(c);
        bus.iX    = 16'(x);
        bus.iY    = 16'(y);
        bus.iEn   = 1'b1;
    endtask

    // Cycles from the start edge to the cycle showing oDone; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i == 0) bus.iEn = 1'b0;
            if (bus.oDone) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input string tag, input logic m, input int s, input int c,
                           input int x, input int y, input int e0, input int e1, input int esat);
        int lat;
        start_txn(m, s, c, x, y);
        wait_done(lat);
        chk({tag, "_latency"}, lat, 6);
        chk({tag, "_out0"}, bus.oOut0, e0);
        chk({tag, "_out1"}, bus.oOut1, e1);
        chk({tag, "_sat"}, bus.oSat, esat);
        chk({tag, "_busy_at_done"}, bus.oBusy, 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, bus.oBusy, 0);
        chk({tag, "_done_pulse"}, bus.oDone, 0);
    endtask

    initial begin
        int    lat;
        int    dones;
        int    changes;
        logic signed [15:0] h0, h1;
        real   th, m0, m1, e0, e1;
        int    s, c, x, y;
        logic  md;

        rst       = 1'b1;
        bus.iEn   = 1'b0;
        bus.iMode = 1'b0;
        bus.iSin  = '0;
        bus.iCos  = '0;
        bus.iX    = '0;
        bus.iY    = '0;
        repeat (3) @(negedge clk);
        chk("rst_out0", bus.oOut0, 0);
        chk("rst_out1", bus.oOut1, 0);
        chk("rst_done", bus.oDone, 0);
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_sat",  bus.oSat, 0);
        rst = 1'b0;

        run_vec("inv_identity", 1'b0, 0, 32767, 16384, 0, 16384, 0, 0);
        run_vec("fwd_90deg",    1'b1, 32767, 0, 16384, 0, 0, -16383, 0);
        run_vec("inv_sat_pos",  1'b0, 23170, 23170, 32767, 32767, 0, 32767, 1);
        run_vec("inv_minmin",   1'b0, 0, -32768, -32768, 0, 32767, 0, 1);
        run_vec("fwd_identity", 1'b1, 0, 32767, -100, 200, -100, 200, 0);

        // Retrigger while busy, then keep iEn high.
        start_txn(1'b0, 0, 32767, 1000, 0);
        @(negedge clk); bus.iEn = 1'b0;
        @(negedge clk); bus.iEn = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.oDone) dones++;
        end
        chk("retrig_one_done", dones, 1);
        chk("retrig_out0", bus.oOut0, 1000);
        chk("retrig_out1", bus.oOut1, 0);
        h0 = bus.oOut0;
        h1 = bus.oOut1;
        changes = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.oOut0 !== h0 || bus.oOut1 !== h1) changes++;
            if (bus.oDone) dones++;
        end
        chk("hold_stable", changes, 0);
        chk("held_en_no_start", dones, 0);
        chk("held_en_idle", bus.oBusy, 0);
        bus.iEn = 1'b0;
        @(negedge clk);

        // Reset in the middle of a transaction.
        start_txn(1'b0, 0, 32767, 5000, 0);
        @(negedge clk); bus.iEn = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_out0", bus.oOut0, 0);
        chk("midrst_out1", bus.oOut1, 0);
        chk("midrst_busy", bus.oBusy, 0);
        chk("midrst_sat",  bus.oSat, 0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.oDone) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run_vec("after_rst", 1'b0, 0, 32767, 5000, 0, 5000, 0, 0);

        // Random angles and operands; |X|,|Y| <= 23000 keeps results in range.
        for (int n = 0; n < 1000; n++) begin
            th = real'($urandom_range(0, 3599)) * 6.283185307179586 / 3600.0;
            s  = int'(32767.0 * $sin(th));
            c  = int'(32767.0 * $cos(th));
            x  = int'($urandom_range(0, 46000)) - 23000;
            y  = int'($urandom_range(0, 46000)) - 23000;
            md = 1'($urandom_range(0, 1));
            if (md == 1'b0) begin
                m0 = (real'(x) * real'(c) - real'(y) * real'(s)) / 32768.0;
                m1 = (real'(x) * real'(s) + real'(y) * real'(c)) / 32768.0;
            end else begin
                m0 = (real'(x) * real'(c) + real'(y) * real'(s)) / 32768.0;
                m1 = (real'(y) * real'(c) - real'(x) * real'(s)) / 32768.0;
            end
            start_txn(md, s, c, x, y);
            wait_done(lat);
            e0 = real'(bus.oOut0) - m0;
            e1 = real'(bus.oOut1) - m1;
            if (e0 < 0.0) e0 = -e0;
            if (e1 < 0.0) e1 = -e1;
            chk("rnd_latency", lat, 6);
            chk("rnd_out0_within_1lsb", (e0 <= 1.0) ? 1 : 0, 1);
            chk("rnd_out1_within_1lsb", (e1 <= 1.0) ? 1 : 0, 1);
            chk("rnd_sat", bus.oSat, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
